// File: rtl/lpm_walk_pkg.sv
// Shared types, field positions and stride table for the LPM trie walker.
package lpm_walk_pkg;

   localparam int unsigned KEY_LO    = 0;
   localparam int unsigned ID_LO     = 32;
   localparam int unsigned BASE_LO   = 64;
   localparam int unsigned KEY_W     = 32;
   localparam int unsigned ID_W      = 32;
   localparam int unsigned LEAF_BIT  = 31;
   localparam int unsigned PAY_W     = 31;
   localparam int unsigned HOP_W     = 29;
   localparam int unsigned IDX_W     = 16;
   localparam int unsigned STRIDE_L0 = 16;
   localparam int unsigned STRIDE_L1 = 8;
   localparam int unsigned STRIDE_L2 = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic             hit;
      logic [1:0]       lvl;
      logic [HOP_W-1:0] hop;
   } result_t;

   // Key slice indexing the table at a given trie level (16/8/8 strides).
   function automatic logic [IDX_W-1:0] stride_idx(input logic [1:0] lvl, input logic [KEY_W-1:0] key);
      case (lvl)
         2'd0:    stride_idx = key[KEY_W-1 -: STRIDE_L0];
         2'd1:    stride_idx = IDX_W'(key[KEY_W-STRIDE_L0-1 -: STRIDE_L1]);
         default: stride_idx = IDX_W'(key[STRIDE_L2-1:0]);
      endcase
   endfunction

endpackage

// File: rtl/lpm_walk_if.sv
// Request, table-memory and result handshakes of the LPM trie walker.
interface lpm_walk_if #(
   parameter int unsigned AW = 24
);
   logic [127:0]  req_first;
   logic          req_first_rdy;
   logic          req_deq_rdy;
   logic          req_deq_ena;
   logic          mem_req_ena;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_rdy;
   logic          mem_resp_ena;
   logic [31:0]   mem_resp_data;
   logic          out_enq_ena;
   logic [63:0]   out_enq_v;
   logic          out_enq_rdy;

   modport slave (
      input  req_first, req_first_rdy, req_deq_rdy, mem_req_rdy, mem_resp_ena, mem_resp_data, out_enq_rdy,
      output req_deq_ena, mem_req_ena, mem_req_addr, out_enq_ena, out_enq_v
   );

   modport master (
      output req_first, req_first_rdy, req_deq_rdy, mem_req_rdy, mem_resp_ena, mem_resp_data, out_enq_rdy,
      input  req_deq_ena, mem_req_ena, mem_req_addr, out_enq_ena, out_enq_v
   );
endinterface

// File: rtl/lpm_walk.sv
// LPM trie walker: dequeues one request, walks a 16/8/8 trie with one read in flight, enqueues the result.
// Define LPM_WALK_STATS_EN to add lookup/miss/read counters as extra outputs.
module lpm_walk
   import lpm_walk_pkg::*;
#(
   parameter int unsigned      AW       = 24,
   parameter logic [HOP_W-1:0] MISS_HOP = 29'h1FFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   lpm_walk_if.slave   bus
`ifdef LPM_WALK_STATS_EN
   ,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_misses,
   output logic [31:0] stat_reads
`endif
);

   state_e           state_q, state_d;
   logic [1:0]       level_q, level_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [AW-1:0]    addr_q, addr_d;
   result_t          res_q, res_d;

   logic             deq_ena, rd_ena, enq_ena;
   logic             leaf;
   logic [PAY_W-1:0] payload;
   logic [KEY_W-1:0] req_key;
   logic             unused_ok;

   assign deq_ena = (state_q == ST_IDLE)  & bus.req_first_rdy & bus.req_deq_rdy;
   assign rd_ena  = (state_q == ST_ISSUE) & bus.mem_req_rdy;
   assign enq_ena = (state_q == ST_DONE)  & bus.out_enq_rdy;

   assign bus.req_deq_ena  = deq_ena;
   assign bus.mem_req_ena  = rd_ena;
   assign bus.out_enq_ena  = enq_ena;
   assign bus.mem_req_addr = addr_q;
   assign bus.out_enq_v    = res_q;

   assign req_key   = bus.req_first[KEY_LO +: KEY_W];
   assign leaf      = bus.mem_resp_data[LEAF_BIT];
   assign payload   = bus.mem_resp_data[PAY_W-1:0];
   assign unused_ok = ^{bus.req_first[127:BASE_LO+AW], payload};

   // Next-state and datapath; the read address is precomputed on entry to ISSUE.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      key_d   = key_q;
      id_d    = id_q;
      addr_d  = addr_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (deq_ena) begin
               key_d   = req_key;
               id_d    = bus.req_first[ID_LO +: ID_W];
               level_d = 2'd0;
               addr_d  = bus.req_first[BASE_LO +: AW] + AW'(stride_idx(2'd0, req_key));
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rd_ena) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mem_resp_ena) begin
               if (leaf) begin
                  res_d.id  = id_q;
                  res_d.hit = 1'b1;
                  res_d.lvl = level_q;
                  res_d.hop = payload[HOP_W-1:0];
                  state_d   = ST_DONE;
               end else if (level_q < 2'd2) begin
                  level_d = 2'(level_q + 2'd1);
                  addr_d  = AW'(payload) + AW'(stride_idx(2'(level_q + 2'd1), key_q));
                  state_d = ST_ISSUE;
               end else begin
                  res_d.id  = id_q;
                  res_d.hit = 1'b0;
                  res_d.lvl = 2'd2;
                  res_d.hop = MISS_HOP;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (enq_ena) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         level_q <= '0;
         key_q   <= '0;
         id_q    <= '0;
         addr_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         key_q   <= key_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         res_q   <= res_d;
      end
   end

`ifdef LPM_WALK_STATS_EN
   logic [31:0] lookups_q, lookups_d, misses_q, misses_d, reads_q, reads_d;

   // Free-running wrapping event counters.
   always_comb begin
      lookups_d = lookups_q + 32'(enq_ena);
      misses_d  = misses_q + 32'(enq_ena & ~res_q.hit);
      reads_d   = reads_q + 32'(rd_ena);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lookups_q <= '0;
         misses_q  <= '0;
         reads_q   <= '0;
      end else begin
         lookups_q <= lookups_d;
         misses_q  <= misses_d;
         reads_q   <= reads_d;
      end
   end

   assign stat_lookups = lookups_q;
   assign stat_misses  = misses_q;
   assign stat_reads   = reads_q;
`endif

endmodule
